emu_rom_arbiter: RTL and testbench

Parametrised ROM-access bridge for the emulation top. It serves CH_NUM independent core-side ROM read channels (boot ROM, ROM2, disk ROM, ...) from one shared emulator-side memory port with a variable-latency handshake. Arbitration is round-robin. Each channel has a one-entry last-read cache and a response timeout. It sits between the machine core's ROM address/data ports and the Verilator-visible memory model, replacing the fixed zero-latency per-ROM signals.

---
 rtl/emu_rom_arbiter.sv | 139 +++++++++++++
 tb/tb_emu_rom_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_rom_arbiter.sv
// ROM-access bridge: round-robin arbitration of CH_NUM core ROM read channels onto one
// variable-latency memory port, with a one-entry last-read cache and a timeout per channel.
module emu_rom_arbiter #(
    parameter int unsigned CH_NUM  = 3,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [CH_NUM-1:0]        i_ch_req,
    input  logic [CH_NUM*ADDR_W-1:0] i_ch_addr,
    output logic [CH_NUM-1:0]        o_ch_ack,
    output logic [CH_NUM-1:0]        o_ch_err,
    output logic [CH_NUM*DATA_W-1:0] o_ch_rdata,
    input  logic                     i_flush,
    output logic                     o_mem_req,
    output logic [CH_W+ADDR_W-1:0]   o_mem_addr,
    input  logic                     i_mem_ack,
    input  logic [DATA_W-1:0]        i_mem_rdata
);

    localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic [CNT_W-1:0]  cnt;
    logic [CH_NUM-1:0] cache_vld;
    logic [ADDR_W-1:0] cache_tag  [CH_NUM];
    logic [DATA_W-1:0] cache_data [CH_NUM];
    logic [DATA_W-1:0] rdata_q    [CH_NUM];

    logic [ADDR_W-1:0] ch_addr [CH_NUM];
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   grant;
    logic              grant_vld;
    logic              hit;

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(CH_NUM - 1)) ? '0 : ch + CH_W'(1);
    endfunction

    // Unpack per-channel addresses and pack per-channel read data
    always_comb begin
        for (int c = 0; c < int'(CH_NUM); c++) begin
            ch_addr[c]                     = i_ch_addr[c*ADDR_W +: ADDR_W];
            o_ch_rdata[c*DATA_W +: DATA_W] = rdata_q[c];
        end
    end

    // Round-robin pick: scan downward so the channel closest to rr_ptr wins
    always_comb begin
        cand      = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            cand = CH_W'((32'(rr_ptr) + 32'(i)) % CH_NUM);
            if (i_ch_req[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
        hit = grant_vld && cache_vld[grant] && (cache_tag[grant] == ch_addr[grant]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cur_ch     <= '0;
            cnt        <= '0;
            cache_vld  <= '0;
            o_ch_ack   <= '0;
            o_ch_err   <= '0;
            o_mem_req  <= 1'b0;
            o_mem_addr <= '0;
            for (int c = 0; c < int'(CH_NUM); c++) begin
                cache_tag[c]  <= '0;
                cache_data[c] <= '0;
                rdata_q[c]    <= '0;
            end
        end else begin
            o_ch_ack <= '0;
            o_ch_err <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        if (hit) begin
                            o_ch_ack[grant] <= 1'b1;
                            rdata_q[grant]  <= cache_data[grant];
                            rr_ptr          <= wrap_inc(grant);
                        end else begin
                            cur_ch     <= grant;
                            o_mem_req  <= 1'b1;
                            o_mem_addr <= {grant, ch_addr[grant]};
                            cnt        <= '0;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // An ack in the expiry cycle takes priority over the timeout
                    if (i_mem_ack) begin
                        o_mem_req          <= 1'b0;
                        o_ch_ack[cur_ch]   <= 1'b1;
                        rdata_q[cur_ch]    <= i_mem_rdata;
                        cache_tag[cur_ch]  <= o_mem_addr[ADDR_W-1:0];
                        cache_data[cur_ch] <= i_mem_rdata;
                        cache_vld[cur_ch]  <= 1'b1;
                        rr_ptr             <= wrap_inc(cur_ch);
                        state              <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST))) begin
                        o_mem_req        <= 1'b0;
                        o_ch_ack[cur_ch] <= 1'b1;
                        o_ch_err[cur_ch] <= 1'b1;
                        rdata_q[cur_ch]  <= '1;
                        state            <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Flush overrides a fill landing on the same edge
            if (i_flush) begin
                cache_vld <= '0;
            end
        end
    end

endmodule

// File: tb/tb_emu_rom_arbiter.sv
// Bench for emu_rom_arbiter: directed scenarios plus randomized rounds against a
// transaction-level model of arbitration order, cache contents and latency.
module tb_emu_rom_arbiter;

    localparam int unsigned CH_NUM  = 3;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned MA_W    = CH_W + ADDR_W;

    logic                     clk;
    logic                     rst_n;
    logic [CH_NUM-1:0]        ch_req;
    logic [CH_NUM*ADDR_W-1:0] ch_addr;
    logic [CH_NUM-1:0]        o_ch_ack;
    logic [CH_NUM-1:0]        o_ch_err;
    logic [CH_NUM*DATA_W-1:0] o_ch_rdata;
    logic                     i_flush;
    logic                     o_mem_req;
    logic [MA_W-1:0]          o_mem_addr;
    logic                     i_mem_ack;
    logic [DATA_W-1:0]        i_mem_rdata;

    emu_rom_arbiter #(
        .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ch_req(ch_req), .i_ch_addr(ch_addr),
        .o_ch_ack(o_ch_ack), .o_ch_err(o_ch_err), .o_ch_rdata(o_ch_rdata), .i_flush(i_flush),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder controls
    int              mem_wait   = 0;
    logic            auto_mem   = 1'b1;
    logic            man_ack    = 1'b0;
    logic [DATA_W-1:0] man_data = '0;
    logic            fixed_en   = 1'b0;
    logic [DATA_W-1:0] fixed_data = '0;
    int              issue_cnt  = 0;
    logic [MA_W-1:0] last_mem_addr = '0;

    // Transaction-level model
    logic              m_vld   [CH_NUM];
    logic [ADDR_W-1:0] m_tag   [CH_NUM];
    logic [DATA_W-1:0] m_data  [CH_NUM];
    logic [DATA_W-1:0] m_rdata [CH_NUM];
    int                m_ptr;

    function automatic logic [DATA_W-1:0] mem_val(input logic [MA_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    function automatic logic [CH_NUM*DATA_W-1:0] model_rdata();
        logic [CH_NUM*DATA_W-1:0] v;
        v = '0;
        for (int c = 0; c < int'(CH_NUM); c++) v[c*DATA_W +: DATA_W] = m_rdata[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < int'(CH_NUM); c++) begin
            m_vld[c] = 1'b0; m_tag[c] = '0; m_data[c] = '0; m_rdata[c] = '0;
        end
        m_ptr = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic set_addr(input int c, input logic [ADDR_W-1:0] a);
        ch_addr[c*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ch_req = '0; i_flush = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks mem_wait cycles after the request rises (never if negative)
    initial begin
        int ack_cnt;
        logic prev_req;
        ack_cnt = 0; prev_req = 1'b0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (o_mem_req && !prev_req) begin
                issue_cnt++;
                ack_cnt = 0;
            end
            prev_req = o_mem_req;
            if (auto_mem) begin
                if (o_mem_req && mem_wait >= 0 && ack_cnt == mem_wait) begin
                    i_mem_ack     = 1'b1;
                    i_mem_rdata   = fixed_en ? fixed_data : mem_val(o_mem_addr);
                    last_mem_addr = o_mem_addr;
                end else begin
                    i_mem_ack = 1'b0;
                end
                if (o_mem_req) ack_cnt++;
            end else begin
                i_mem_ack   = man_ack;
                i_mem_rdata = man_data;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; ch_req = '0; ch_addr = '0; i_flush = 1'b0;
        cyc(); cyc();
        n_tests++; if (o_ch_ack !== '0 || o_ch_err !== '0) begin n_fail++; $display("FAIL reset_ack_err: ack=%b err=%b expected 000/000", o_ch_ack, o_ch_err); end
        n_tests++; if (o_ch_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", o_ch_rdata); end
        n_tests++; if (o_mem_req !== 1'b0 || o_mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem: req=%b addr=%h expected 0/0", o_mem_req, o_mem_addr); end
        rst_n = 1'b1;
        model_reset();
        cyc();
        n_tests++; if (o_mem_req !== 1'b0 || o_ch_ack !== '0) begin n_fail++; $display("FAIL idle_quiet: req=%b ack=%b expected 0", o_mem_req, o_ch_ack); end
    endtask

    task automatic test_miss();
        int lat;
        fixed_en = 1'b1; fixed_data = 8'hA5; mem_wait = 2;
        set_addr(1, 20'h00123); ch_req = 3'b010;
        cyc();
        n_tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== {2'd1, 20'h00123}) begin n_fail++; $display("FAIL miss_issue: req=%b addr=%h expected 1/%h", o_mem_req, o_mem_addr, {2'd1, 20'h00123}); end
        lat = 1;
        while (o_ch_ack === '0 && lat < 12) begin cyc(); lat++; end
        n_tests++; if (o_ch_ack !== 3'b010 || o_ch_err !== 3'b000) begin n_fail++; $display("FAIL miss_ack: ack=%b err=%b expected 010/000", o_ch_ack, o_ch_err); end
        n_tests++; if (o_ch_rdata[DATA_W +: DATA_W] !== 8'hA5) begin n_fail++; $display("FAIL miss_rdata: got %h expected a5", o_ch_rdata[DATA_W +: DATA_W]); end
        n_tests++; if (lat != 4 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL miss_latency: lat=%0d req=%b expected 4/0", lat, o_mem_req); end
        ch_req = '0;
        cyc();
        n_tests++; if (o_ch_ack !== '0) begin n_fail++; $display("FAIL ack_pulse: ack=%b expected 000", o_ch_ack); end
    endtask

    task automatic test_hit_flush();
        int base, lat;
        base = issue_cnt;
        ch_req = 3'b010;
        cyc();
        n_tests++; if (o_ch_ack !== 3'b010 || o_ch_rdata[DATA_W +: DATA_W] !== 8'hA5) begin n_fail++; $display("FAIL hit: ack=%b data=%h expected 010/a5", o_ch_ack, o_ch_rdata[DATA_W +: DATA_W]); end
        n_tests++; if (o_mem_req !== 1'b0 || issue_cnt != base) begin n_fail++; $display("FAIL hit_no_mem: req=%b issues=%0d expected 0/%0d", o_mem_req, issue_cnt, base); end
        ch_req = '0; cyc();
        i_flush = 1'b1; cyc(); i_flush = 1'b0;
        ch_req = 3'b010;
        cyc();
        n_tests++; if (o_mem_req !== 1'b1 || o_ch_ack !== '0) begin n_fail++; $display("FAIL flush_miss: req=%b ack=%b expected 1/000", o_mem_req, o_ch_ack); end
        lat = 1;
        while (o_ch_ack === '0 && lat < 12) begin cyc(); lat++; end
        n_tests++; if (o_ch_ack !== 3'b010 || o_ch_rdata[DATA_W +: DATA_W] !== 8'hA5) begin n_fail++; $display("FAIL refill: ack=%b data=%h expected 010/a5", o_ch_ack, o_ch_rdata[DATA_W +: DATA_W]); end
        ch_req = '0; cyc();
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] a [CH_NUM];
        logic [CH_NUM-1:0] exp_ack;
        int order [2];
        int lat, c;
        do_reset();
        fixed_en = 1'b0; mem_wait = 0;
        a[0] = 20'h01000; a[1] = 20'h02000; a[2] = 20'h03000;
        for (int k = 0; k < 3; k++) set_addr(k, a[k]);
        ch_req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            do begin cyc(); lat++; end while (o_ch_ack === '0 && lat < 12);
            exp_ack = '0; exp_ack[k] = 1'b1;
            n_tests++; if (o_ch_ack !== exp_ack || lat != 2) begin n_fail++; $display("FAIL rr_order%0d: ack=%b lat=%0d expected %b/2", k, o_ch_ack, lat, exp_ack); end
            n_tests++; if (o_ch_rdata[k*DATA_W +: DATA_W] !== mem_val({CH_W'(k), a[k]})) begin n_fail++; $display("FAIL rr_data%0d: got %h expected %h", k, o_ch_rdata[k*DATA_W +: DATA_W], mem_val({CH_W'(k), a[k]})); end
            ch_req[k] = 1'b0;
        end
        // Pointer has wrapped to 0: ch0 then ch2
        set_addr(0, 20'h01001); set_addr(2, 20'h03001);
        ch_req = 3'b101;
        order[0] = 0; order[1] = 2;
        for (int k = 0; k < 2; k++) begin
            c = order[k];
            lat = 0;
            do begin cyc(); lat++; end while (o_ch_ack === '0 && lat < 12);
            exp_ack = '0; exp_ack[c] = 1'b1;
            n_tests++; if (o_ch_ack !== exp_ack || lat != 2) begin n_fail++; $display("FAIL rr_wrap%0d: ack=%b lat=%0d expected %b/2", k, o_ch_ack, lat, exp_ack); end
            ch_req[c] = 1'b0;
        end
        cyc();
    endtask

    task automatic test_timeout();
        int base, lat, hi;
        mem_wait = -1;
        set_addr(2, 20'h0ABCD); ch_req = 3'b100;
        base = issue_cnt;
        lat = 0; hi = 0;
        do begin cyc(); lat++; if (o_mem_req) hi++; end while (o_ch_ack === '0 && lat < 12);
        n_tests++; if (o_ch_ack !== 3'b100 || o_ch_err !== 3'b100) begin n_fail++; $display("FAIL tmo_ack_err: ack=%b err=%b expected 100/100", o_ch_ack, o_ch_err); end
        n_tests++; if (o_ch_rdata[2*DATA_W +: DATA_W] !== 8'hFF) begin n_fail++; $display("FAIL tmo_rdata: got %h expected ff", o_ch_rdata[2*DATA_W +: DATA_W]); end
        n_tests++; if (lat != 5 || hi != 4 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_timing: lat=%0d req_cycles=%0d req=%b expected 5/4/0", lat, hi, o_mem_req); end
        ch_req = '0; cyc();
        n_tests++; if (o_ch_err !== '0) begin n_fail++; $display("FAIL tmo_err_pulse: err=%b expected 000", o_ch_err); end
        mem_wait = 0; ch_req = 3'b100;
        cyc();
        n_tests++; if (o_mem_req !== 1'b1 || issue_cnt != base + 2) begin n_fail++; $display("FAIL tmo_no_cache: req=%b issues=%0d expected 1/%0d", o_mem_req, issue_cnt, base + 2); end
        lat = 1;
        while (o_ch_ack === '0 && lat < 12) begin cyc(); lat++; end
        ch_req = '0; cyc();
    endtask

    task automatic test_reset_mid();
        auto_mem = 1'b0; man_ack = 1'b0; man_data = 8'h99;
        set_addr(0, 20'h00777); ch_req = 3'b001;
        cyc();
        n_tests++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: req=%b expected 1", o_mem_req); end
        cyc();
        rst_n = 1'b0; ch_req = '0;
        cyc();
        rst_n = 1'b1; model_reset();
        man_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++; if (o_ch_ack !== '0 || o_mem_req !== 1'b0 || o_ch_rdata !== '0) begin n_fail++; $display("FAIL rmid_late_ack%0d: ack=%b req=%b rdata=%h expected 000/0/0", k, o_ch_ack, o_mem_req, o_ch_rdata); end
        end
        man_ack = 1'b0; auto_mem = 1'b1; mem_wait = 0;
        ch_req = 3'b100;
        cyc();
        n_tests++; if (o_mem_req !== 1'b1 || o_ch_ack !== '0) begin n_fail++; $display("FAIL rmid_cache_empty: req=%b ack=%b expected 1/000", o_mem_req, o_ch_ack); end
        while (o_ch_ack === '0 && o_mem_req === 1'b1) cyc();
        ch_req = '0; cyc();
    endtask

    task automatic test_ack_expiry();
        int base, lat;
        fixed_en = 1'b1; fixed_data = 8'h3C; mem_wait = 3;
        set_addr(1, 20'h55555); ch_req = 3'b010;
        lat = 0;
        do begin cyc(); lat++; end while (o_ch_ack === '0 && lat < 12);
        n_tests++; if (o_ch_ack !== 3'b010 || o_ch_err !== 3'b000 || lat != 5) begin n_fail++; $display("FAIL expiry_ack: ack=%b err=%b lat=%0d expected 010/000/5", o_ch_ack, o_ch_err, lat); end
        n_tests++; if (o_ch_rdata[DATA_W +: DATA_W] !== 8'h3C) begin n_fail++; $display("FAIL expiry_data: got %h expected 3c", o_ch_rdata[DATA_W +: DATA_W]); end
        ch_req = '0; cyc();
        base = issue_cnt;
        ch_req = 3'b010;
        cyc();
        n_tests++; if (o_ch_ack !== 3'b010 || o_ch_rdata[DATA_W +: DATA_W] !== 8'h3C || issue_cnt != base) begin n_fail++; $display("FAIL expiry_cached: ack=%b data=%h issues=%0d expected 010/3c/%0d", o_ch_ack, o_ch_rdata[DATA_W +: DATA_W], issue_cnt, base); end
        ch_req = '0; cyc();
    endtask

    task automatic test_flush_corner();
        int lat;
        fixed_en = 1'b1; fixed_data = 8'h6B; mem_wait = 0;
        set_addr(0, 20'h0F0F0); ch_req = 3'b001;
        cyc();
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        n_tests++; if (o_ch_ack !== 3'b001 || o_ch_rdata[0 +: DATA_W] !== 8'h6B) begin n_fail++; $display("FAIL flush_fill: ack=%b data=%h expected 001/6b", o_ch_ack, o_ch_rdata[0 +: DATA_W]); end
        ch_req = '0; cyc();
        ch_req = 3'b001;
        cyc();
        n_tests++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_fill_invalid: req=%b expected 1", o_mem_req); end
        lat = 1;
        while (o_ch_ack === '0 && lat < 12) begin cyc(); lat++; end
        ch_req = '0; cyc();
        ch_req = 3'b001; i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        n_tests++; if (o_ch_ack !== 3'b001 || o_mem_req !== 1'b0 || o_ch_rdata[0 +: DATA_W] !== 8'h6B) begin n_fail++; $display("FAIL flush_hit: ack=%b req=%b data=%h expected 001/0/6b", o_ch_ack, o_mem_req, o_ch_rdata[0 +: DATA_W]); end
        ch_req = '0; cyc();
        ch_req = 3'b001;
        cyc();
        n_tests++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_hit_after: req=%b expected 1", o_mem_req); end
        lat = 1;
        while (o_ch_ack === '0 && lat < 12) begin cyc(); lat++; end
        ch_req = '0; cyc();
    endtask

    task automatic test_random();
        do_reset();
        fixed_en = 1'b0;
        for (int r = 0; r < 40; r++) begin
            logic [ADDR_W-1:0] ra [CH_NUM];
            logic [CH_NUM-1:0] mask, exp_ack, exp_err;
            int order [$];
            int mw, c, lat, base, exp_lat, exp_iss;
            logic hit, tmo;
            if ($urandom_range(0, 3) == 0) begin
                i_flush = 1'b1; cyc(); i_flush = 1'b0;
                for (int k = 0; k < int'(CH_NUM); k++) m_vld[k] = 1'b0;
            end
            mask = CH_NUM'($urandom_range(1, 7));
            mw = int'($urandom_range(0, 5));
            if (mw == 5) mw = -1;
            mem_wait = mw;
            for (int k = 0; k < int'(CH_NUM); k++) begin
                ra[k] = 20'(32'h00100 + $urandom_range(0, 2));
                set_addr(k, ra[k]);
            end
            for (int i = 0; i < int'(CH_NUM); i++) begin
                c = (m_ptr + i) % int'(CH_NUM);
                if (mask[c]) order.push_back(c);
            end
            ch_req = mask;
            foreach (order[k]) begin
                c = order[k];
                hit = m_vld[c] && (m_tag[c] == ra[c]);
                tmo = !hit && (mw < 0 || mw > int'(TIMEOUT) - 1);
                exp_lat = hit ? 1 : (tmo ? int'(TIMEOUT) + 1 : mw + 2);
                exp_iss = hit ? 0 : 1;
                exp_ack = '0; exp_ack[c] = 1'b1;
                exp_err = tmo ? exp_ack : '0;
                if (hit) begin
                    m_rdata[c] = m_data[c];
                    m_ptr = (c + 1) % int'(CH_NUM);
                end else if (tmo) begin
                    m_rdata[c] = '1;
                end else begin
                    m_data[c] = mem_val({CH_W'(c), ra[c]});
                    m_rdata[c] = m_data[c];
                    m_tag[c] = ra[c];
                    m_vld[c] = 1'b1;
                    m_ptr = (c + 1) % int'(CH_NUM);
                end
                base = issue_cnt;
                lat = 0;
                do begin cyc(); lat++; end while (o_ch_ack === '0 && lat < 12);
                n_tests++; if (o_ch_ack !== exp_ack || o_ch_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_ack: ack=%b err=%b expected %b/%b", r, o_ch_ack, o_ch_err, exp_ack, exp_err); end
                n_tests++; if (o_ch_rdata !== model_rdata()) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h expected %h", r, o_ch_rdata, model_rdata()); end
                n_tests++; if (lat != exp_lat || issue_cnt != base + exp_iss) begin n_fail++; $display("FAIL rnd%0d_timing: lat=%0d issues=%0d expected %0d/%0d", r, lat, issue_cnt - base, exp_lat, exp_iss); end
                if (!hit && !tmo) begin
                    n_tests++; if (last_mem_addr !== {CH_W'(c), ra[c]}) begin n_fail++; $display("FAIL rnd%0d_memaddr: got %h expected %h", r, last_mem_addr, {CH_W'(c), ra[c]}); end
                end
                ch_req[c] = 1'b0;
            end
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0; ch_req = '0; ch_addr = '0; i_flush = 1'b0;
        model_reset();
        test_reset();
        test_miss();
        test_hit_flush();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_ack_expiry();
        test_flush_corner();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
